// File: rtl/digit_serial_add_seq.sv
// Digit-serial adder sequencer.
// Streams two WIDTH-bit operands, two bits per cycle and LSB digit first,
// through an external 2-bit adder slice. The carry is registered between
// digits and the returned sum digits are assembled into a WIDTH-bit result.
// Host handshake: start (accepted in IDLE or DONE), busy while digits are
// streaming, and a one-cycle done pulse when sum/cout_final are valid.
// WIDTH must be even and >= 4.
module digit_serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             a1,
    output logic             a0,
    output logic             b1,
    output logic             b0,
    output logic             c0,
    input  logic             s1,
    input  logic             s0,
    input  logic             cout,
    output logic [WIDTH-1:0] sum,
    output logic             cout_final,
    output logic             done
);

    localparam int ND = WIDTH / 2;      // digits per operation
    localparam int CW = $clog2(ND);     // digit counter width

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout_final;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             w_last_digit;

    // Last digit of the operation is being added on this cycle.
    assign w_last_digit = (r_cnt == CW'(ND - 1));

    // Sequencer FSM: load on accepted start, shift one digit per RUN edge,
    // pulse done for one cycle. busy/done are registered with the state.
    // NOTE: every register, including the data shift registers, is cleared by
    // the async reset so a reset mid-operation leaves no stale digits behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_sum        <= '0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_cout_final <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every right-hand
            // side reads the pre-edge value (the shifts depend on this).
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_sum   <= {s1, s0, r_sum[WIDTH-1:2]};
                    r_carry <= cout;
                    r_a_sh  <= {2'b00, r_a_sh[WIDTH-1:2]};
                    r_b_sh  <= {2'b00, r_b_sh[WIDTH-1:2]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last_digit) begin
                        r_cout_final <= cout;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Slice inputs are only driven while digits are streaming.
    assign a1 = r_busy & r_a_sh[1];
    assign a0 = r_busy & r_a_sh[0];
    assign b1 = r_busy & r_b_sh[1];
    assign b0 = r_busy & r_b_sh[0];
    assign c0 = r_busy & r_carry;

    assign busy       = r_busy;
    assign done       = r_done;
    assign sum        = r_sum;
    assign cout_final = r_cout_final;

endmodule

// File: tb/tb_digit_serial_add_seq.sv
// Testbench for digit_serial_add_seq (WIDTH=8) with a behavioural 2-bit slice.
// A per-operation model (remaining-cycle count plus a+b+cin) is checked
// against the DUT on every falling edge; directed tests pin literal results.
module tb_digit_serial_add_seq;

    localparam int W  = 8;
    localparam int ND = W / 2;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         cin   = 1'b0;
    logic         busy, a1, a0, b1, b0, c0, s1, s0, cout, cout_final, done;
    logic [W-1:0] sum;

    int n_checks = 0;
    int n_pass   = 0;

    digit_serial_add_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .a1(a1), .a0(a0), .b1(b1), .b0(b0), .c0(c0),
        .s1(s1), .s0(s0), .cout(cout),
        .sum(sum), .cout_final(cout_final), .done(done)
    );

    // Behavioural 2-bit adder slice.
    assign {cout, s1, s0} = {1'b0, a1, a0} + {1'b0, b1, b0} + {2'b00, c0};

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Operation-level model: an accepted op occupies ND busy cycles, then one
    // done cycle presenting a+b+cin.
    int           m_left   = 0;
    bit           m_done   = 1'b0;
    int           m_a      = 0;
    int           m_b      = 0;
    int           m_cin    = 0;
    logic [W:0]   m_result = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   <= 0;
            m_done   <= 1'b0;
            m_result <= '0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) m_result <= (W+1)'(m_a + m_b + m_cin);
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= ND;
                m_a    <= int'(a);
                m_b    <= int'(b);
                m_cin  <= int'(cin);
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, 32'(m_left != 0));
            check("done", done, 32'(m_done));
            if (m_left == 0) begin
                check("result_held", {cout_final, sum}, m_result);
                check("slice_idle", {a1, a0, b1, b0, c0}, 0);
            end else begin
                int k, mask;
                k    = ND - m_left;
                mask = (1 << (2 * k)) - 1;
                check("a_digit", {a1, a0}, (m_a >> (2 * k)) & 3);
                check("b_digit", {b1, b0}, (m_b >> (2 * k)) & 3);
                check("carry_in", c0, ((m_a & mask) + (m_b & mask) + m_cin) >> (2 * k));
            end
        end
    end

    task automatic wait_done(output bit ok, output int nb);
        ok = 1'b0;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) nb++;
            @(negedge clk);
        end
    endtask

    // Issue one op at the current falling edge and check the literal result.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic oc,
                         input logic [W:0] exp);
        bit ok;
        int nb;
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(negedge clk);
        start = 1'b0;
        wait_done(ok, nb);
        check("done_seen", ok, 1);
        check("busy_cycles", nb, ND);
        check("op_result", {cout_final, sum}, exp);
    endtask

    initial begin
        bit ok;
        int nb, gap;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout_final", cout_final, 0);
        check("rst_slice", {a1, a0, b1, b0, c0}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h5A, 8'h3C, 1'b0, 9'h096);
        do_op(8'hFF, 8'h01, 1'b0, 9'h100);
        do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF);
        do_op(8'h00, 8'h00, 1'b0, 9'h000);
        @(negedge clk);

        // start held through RUN with changing operands, then still high in DONE.
        start = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
        for (int i = 0; i < ND; i++) begin
            @(negedge clk);
            check("hold_busy", busy, 1);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("hold_done", done, 1);
        check("hold_result", {cout_final, sum}, 9'h033);
        a = 8'h40; b = 8'h05; cin = 1'b1;
        @(negedge clk);
        check("b2b_busy", busy, 1);
        start = 1'b0;
        wait_done(ok, nb);
        check("b2b_done_seen", ok, 1);
        check("b2b_result", {cout_final, sum}, 9'h046);
        @(negedge clk);

        // Reset during the second RUN cycle aborts the op.
        start = 1'b1; a = 8'hAA; b = 8'h55; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_slice", {a1, a0, b1, b0, c0}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h12, 8'h34, 1'b0, 9'h046);

        // Random ops with random gaps, including back-to-back starts in DONE.
        for (int i = 0; i < 1000; i++) begin
            start = 1'b1;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
            @(negedge clk);
            start = 1'b0;
            wait_done(ok, nb);
            check("rand_done_seen", ok, 1);
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
